// File: rtl/wb_port_if.sv
// Write-back port bundle: load and ALU result inputs plus the register-file write side.
// The master drives results in and the slave (the scheduler) drives the RF write.
interface wb_port_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 6
) ();
    logic              mem_valid;
    logic [REG_W-1:0]  mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              alu_valid;
    logic [REG_W-1:0]  alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_stall;
    logic              rf_we;
    logic [REG_W-1:0]  rf_rd;
    logic [DATA_W-1:0] rf_wdata;
    logic              pending;
    logic [15:0]       wb_count;

    modport master (
        output mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data,
        input  alu_stall, rf_we, rf_rd, rf_wdata, pending, wb_count
    );

    modport slave (
        input  mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data,
        output alu_stall, rf_we, rf_rd, rf_wdata, pending, wb_count
    );
endinterface

// File: rtl/wb_port_scheduler.sv
// Shares one register-file write port between loads (absolute priority) and ALU results,
// parking ALU results that lose arbitration in a small in-order skid FIFO.
module wb_port_scheduler #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 6,
    parameter int DEPTH  = 2
) (
    input logic      clk,
    input logic      rst_n,
    wb_port_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_ent_t;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_MEM,
        SRC_FIFO,
        SRC_ALU
    } src_e;

    wb_ent_t           fifo_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rf_we_q, rf_we_d;
    logic [REG_W-1:0]  rf_rd_q, rf_rd_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic [15:0]       wb_count_q, wb_count_d;

    src_e    grant;
    wb_ent_t grant_ent;
    wb_ent_t alu_ent;
    logic    fifo_empty;
    logic    fifo_full;
    logic    alu_accept;
    logic    push;
    logic    pop;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_W'(DEPTH));
        alu_ent    = '{rd: bus.alu_rd, data: bus.alu_data};
        alu_accept = bus.alu_valid && !fifo_full;
        grant      = SRC_NONE;
        grant_ent  = '0;
        pop        = 1'b0;

        if (bus.mem_valid) begin
            grant     = SRC_MEM;
            grant_ent = '{rd: bus.mem_rd, data: bus.mem_data};
        end else if (!fifo_empty) begin
            grant     = SRC_FIFO;
            grant_ent = fifo_q[rd_ptr_q];
            pop       = 1'b1;
        end else if (alu_accept) begin
            grant     = SRC_ALU;
            grant_ent = alu_ent;
        end

        // An accepted ALU result either wins the port directly or queues behind older ones.
        push = alu_accept && (grant != SRC_ALU);

        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Writes to r0 still use up the slot but never reach the register file.
        rf_we_d    = (grant != SRC_NONE) && (grant_ent.rd != '0);
        rf_rd_d    = (grant != SRC_NONE) ? grant_ent.rd   : rf_rd_q;
        rf_wdata_d = (grant != SRC_NONE) ? grant_ent.data : rf_wdata_q;
        wb_count_d = wb_count_q + 16'(rf_we_d);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
            wb_count_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
            wb_count_q <= wb_count_d;
        end
    end

    // NOTE: FIFO storage is not reset; count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            fifo_q[wr_ptr_q] <= alu_ent;
        end
    end

    assign bus.alu_stall = fifo_full;
    assign bus.pending   = !fifo_empty;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_rd     = rf_rd_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.wb_count  = wb_count_q;
endmodule
